// File: rtl/comb_seq_pkg.sv
// comb_seq_pkg: shared definitions for the combinational-block sequencer.
//   state_t : FSM state encoding (IDLE=0 .. FINISH=4, 3 bits)
//   NUM_VEC : number of input vectors swept (all 2^3 combinations)
//   IDX_W   : width of the vector index / {D,X,A} drive
//   CNT_W   : width of the settle counter and the mismatch counter
package comb_seq_pkg;

  localparam int NUM_VEC = 8;
  localparam int IDX_W   = 3;
  localparam int CNT_W   = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    APPLY  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    FINISH = 3'd4
  } state_t;

endpackage

// File: rtl/comb_seq_ctrl_settle_timer.sv
// settle_timer: loadable down-counter that times the settle window.
//   clk, rst_n : clock and asynchronous active-low reset
//   load       : loads LOAD_VAL into the counter
//   en         : counts down one step per cycle while high
//   expire     : high during the last enabled cycle of the window
// With LOAD_VAL = N, expire is seen in the N-th enabled cycle after a
// load, so the window is exactly N cycles long (N >= 1).
module settle_timer #(
  parameter int              WIDTH    = 4,
  parameter logic [WIDTH-1:0] LOAD_VAL = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expire
);

  logic [WIDTH-1:0] count;

  // Count down from LOAD_VAL; parks at zero once the window has run out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expire = en && (count == WIDTH'(1));

endmodule

// File: rtl/comb_seq_ctrl.sv
// comb_seq_ctrl: exhaustive in-system checker for a 3-input logic block.
// Drives {D,X,A} through vectors 0..7, waits SETTLE_CYCLES per vector,
// samples L, and scores the captured truth table against 'expected'.
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : begin a sweep (only honoured in IDLE)
//   abort          : cancel a running sweep
//   expected[7:0]  : expected L for each vector, bit i <-> {D,X,A}==i
//   D, X, A        : vector drive to the logic block (D is the MSB)
//   L              : logic block output
//   busy           : high in every state except IDLE
//   done           : one-cycle pulse when a sweep completes
//   truth[7:0]     : captured L values, bit i from vector i
//   pass           : captured table matched expected on the last sweep
//   mismatch_cnt   : number of mismatching vectors (0..8)
//   first_fail_idx : lowest failing vector, 0 when none
//   first_fail_vld : at least one mismatch seen
module comb_seq_ctrl
  import comb_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       expected,
  output logic             D,
  output logic             X,
  output logic             A,
  input  logic             L,
  output logic             busy,
  output logic             done,
  output logic [7:0]       truth,
  output logic             pass,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [IDX_W-1:0] first_fail_idx,
  output logic             first_fail_vld
);

  // The settle counter is 4 bits wide, so only 1..15 can be represented.
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("comb_seq_ctrl: SETTLE_CYCLES must be in 1..15");
  end

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_VEC - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             settle_done;
  logic             l_mismatch;

  // The index register is the vector drive itself; it is cleared whenever
  // the FSM returns to IDLE, so {D,X,A} reads 000 there.
  assign {D, X, A}  = idx;
  assign l_mismatch = (L != expected[idx]);

  settle_timer #(
    .WIDTH    (CNT_W),
    .LOAD_VAL (SETTLE_LOAD)
  ) u_settle_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (state == APPLY),
    .en     (state == SETTLE),
    .expire (settle_done)
  );

  // Sweep FSM, index counter and scoreboard. Abort overrides every
  // transition out of a busy state; done is raised on the edge entering
  // FINISH so it is high for exactly the FINISH cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      idx            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      truth          <= '0;
      pass           <= 1'b0;
      mismatch_cnt   <= '0;
      first_fail_idx <= '0;
      first_fail_vld <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          state          <= APPLY;
          busy           <= 1'b1;
          idx            <= '0;
          truth          <= '0;
          pass           <= 1'b0;
          mismatch_cnt   <= '0;
          first_fail_idx <= '0;
          first_fail_vld <= 1'b0;
        end
      end else if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
        idx   <= '0;
        pass  <= 1'b0;
      end else begin
        case (state)
          APPLY: begin
            state <= SETTLE;
          end
          SETTLE: begin
            if (settle_done) begin
              state <= SAMPLE;
            end
          end
          SAMPLE: begin
            truth[idx] <= L;
            if (l_mismatch) begin
              mismatch_cnt <= mismatch_cnt + 4'd1;
              if (!first_fail_vld) begin
                first_fail_idx <= idx;
                first_fail_vld <= 1'b1;
              end
            end
            if (idx == LAST_IDX) begin
              // The count register has not yet absorbed this vector.
              state <= FINISH;
              done  <= 1'b1;
              pass  <= (mismatch_cnt == '0) && !l_mismatch;
            end else begin
              idx   <= idx + 1'b1;
              state <= APPLY;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
            idx   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_comb_seq_ctrl.sv
// tb_comb_seq_ctrl: self-checking bench for comb_seq_ctrl.
// The logic block is modelled as a lookup into 'golden'; an alternative
// slow model only shows the right value once a vector has been stable
// for four clock cycles. A second instance runs with SETTLE_CYCLES=1.
module tb_comb_seq_ctrl;

  localparam int S     = 2;
  localparam int PER   = S + 2;
  localparam int SWEEP = 8 * PER;

  logic       clk;
  logic       rst_n;
  logic       start, abort;
  logic [7:0] expected;
  logic       D, X, A, L;
  logic       busy, done, pass, first_fail_vld;
  logic [7:0] truth;
  logic [3:0] mismatch_cnt;
  logic [2:0] first_fail_idx;

  logic       start1, abort1;
  logic [7:0] expected1;
  logic       d1, x1, a1, l1;
  logic       busy1, done1, pass1, ffv1;
  logic [7:0] truth1;
  logic [3:0] cnt1;
  logic [2:0] ffi1;

  logic [7:0] golden;
  bit         slow_mode;
  logic [2:0] prev_vec, prev_vec1;
  int         stable, stable1;
  logic       l_slow, l_slow1;

  int errors;
  int checks;

  comb_seq_ctrl #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .expected(expected), .D(D), .X(X), .A(A), .L(L),
    .busy(busy), .done(done), .truth(truth), .pass(pass),
    .mismatch_cnt(mismatch_cnt), .first_fail_idx(first_fail_idx),
    .first_fail_vld(first_fail_vld)
  );

  comb_seq_ctrl #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .expected(expected1), .D(d1), .X(x1), .A(a1), .L(l1),
    .busy(busy1), .done(done1), .truth(truth1), .pass(pass1),
    .mismatch_cnt(cnt1), .first_fail_idx(ffi1), .first_fail_vld(ffv1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slow logic block: wrong value until the vector has been held for
  // four cycles, then the golden value.
  always @(negedge clk) begin
    if ({D, X, A} != prev_vec) begin
      stable <= 1;
      l_slow <= ~golden[{D, X, A}];
    end else begin
      stable <= stable + 1;
      l_slow <= (stable + 1 >= 4) ? golden[{D, X, A}] : ~golden[{D, X, A}];
    end
    prev_vec <= {D, X, A};
  end

  always @(negedge clk) begin
    if ({d1, x1, a1} != prev_vec1) begin
      stable1 <= 1;
      l_slow1 <= ~golden[{d1, x1, a1}];
    end else begin
      stable1 <= stable1 + 1;
      l_slow1 <= (stable1 + 1 >= 4) ? golden[{d1, x1, a1}] : ~golden[{d1, x1, a1}];
    end
    prev_vec1 <= {d1, x1, a1};
  end

  assign L  = slow_mode ? l_slow : golden[{D, X, A}];
  assign l1 = l_slow1;

  // Reference scoreboard over the first nvec vectors.
  function automatic void model_sweep(input logic [7:0] gold, input logic [7:0] exp_tbl,
                                      input int nvec, output logic [7:0] t,
                                      output logic [3:0] cnt, output logic [2:0] ffi,
                                      output logic ffv);
    t = '0; cnt = '0; ffi = '0; ffv = 1'b0;
    for (int i = 0; i < nvec; i++) begin
      t[i] = gold[i];
      if (gold[i] != exp_tbl[i]) begin
        cnt = cnt + 4'd1;
        if (!ffv) begin
          ffv = 1'b1;
          ffi = 3'(i);
        end
      end
    end
  endfunction

  // Run one full sweep on the main instance, watching vector order, busy
  // and the done pulse relative to the accepting edge.
  task automatic do_sweep(input logic [7:0] exp_tbl, input bit repulse, input bit with_abort,
                          output int done_edge, output int done_pulses,
                          output int seq_err, output bit busy_ok);
    logic [2:0] vexp;
    expected = exp_tbl;
    start = 1'b1;
    abort = with_abort;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    busy_ok = (busy === 1'b1);
    done_edge = -1; done_pulses = 0; seq_err = 0;
    for (int n = 0; n < SWEEP + 6; n++) begin
      vexp = 3'(n / PER);
      if (n < SWEEP && {D, X, A} !== vexp) seq_err++;
      if (done === 1'b1) begin
        done_pulses++;
        if (done_edge < 0) done_edge = n;
      end
      if (repulse && (n == 2 * PER + 1 || n == 5 * PER + 1)) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; expected = '0;
    start1 = 1'b0; abort1 = 1'b0; expected1 = '0;
    golden = 8'hE2; slow_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, D, X, A, pass, first_fail_vld, first_fail_idx, mismatch_cnt, truth} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_in: got busy=%b done=%b dxa=%b truth=%h want all zero",
               busy, done, {D, X, A}, truth);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, D, X, A, pass, first_fail_vld, first_fail_idx, mismatch_cnt, truth} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_out: got busy=%b done=%b dxa=%b truth=%h want all zero",
               busy, done, {D, X, A}, truth);
    end
  endtask

  task automatic test_match;
    int de, dp, se; bit bo;
    golden = 8'hE2;
    do_sweep(8'hE2, 1'b0, 1'b0, de, dp, se, bo);
    checks++; if (!bo) begin errors++; $display("[TB] FAIL match_busy: got %b want 1", bo); end
    checks++; if (se != 0) begin errors++; $display("[TB] FAIL match_seq: got %0d bad cycles want 0", se); end
    checks++; if (de != SWEEP) begin errors++; $display("[TB] FAIL match_done_edge: got %0d want %0d", de, SWEEP); end
    checks++; if (dp != 1) begin errors++; $display("[TB] FAIL match_done_pulses: got %0d want 1", dp); end
    checks++; if (truth !== 8'hE2) begin errors++; $display("[TB] FAIL match_truth: got %h want e2", truth); end
    checks++; if (pass !== 1'b1) begin errors++; $display("[TB] FAIL match_pass: got %b want 1", pass); end
    checks++; if (mismatch_cnt !== 4'd0) begin errors++; $display("[TB] FAIL match_cnt: got %0d want 0", mismatch_cnt); end
    checks++; if (first_fail_vld !== 1'b0) begin errors++; $display("[TB] FAIL match_ffv: got %b want 0", first_fail_vld); end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (truth !== 8'hE2 || pass !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL match_hold: got truth=%h pass=%b busy=%b want e2 1 0", truth, pass, busy);
    end
  endtask

  task automatic test_mismatch;
    int de, dp, se; bit bo;
    logic [7:0] et, exps [2];
    logic [3:0] ec; logic [2:0] ei; logic ev;
    exps[0] = 8'hE3; exps[1] = 8'h1D;
    golden = 8'hE2;
    foreach (exps[k]) begin
      do_sweep(exps[k], 1'b0, 1'b0, de, dp, se, bo);
      model_sweep(golden, exps[k], 8, et, ec, ei, ev);
      checks++; if (truth !== et) begin errors++; $display("[TB] FAIL mism_truth: got %h want %h", truth, et); end
      checks++; if (pass !== 1'b0) begin errors++; $display("[TB] FAIL mism_pass: got %b want 0", pass); end
      checks++; if (mismatch_cnt !== ec) begin errors++; $display("[TB] FAIL mism_cnt: got %0d want %0d", mismatch_cnt, ec); end
      checks++; if (first_fail_idx !== ei || first_fail_vld !== ev) begin
        errors++;
        $display("[TB] FAIL mism_first: got idx=%0d vld=%b want idx=%0d vld=%b", first_fail_idx, first_fail_vld, ei, ev);
      end
    end
  endtask

  task automatic test_settle;
    int de, dp, se, de1; bit bo;
    logic [7:0] et1;
    golden = 8'hE2;
    slow_mode = 1'b1;
    do_sweep(8'hE2, 1'b0, 1'b0, de, dp, se, bo);
    slow_mode = 1'b0;
    checks++; if (pass !== 1'b1 || truth !== 8'hE2) begin
      errors++; $display("[TB] FAIL settle2_pass: got pass=%b truth=%h want 1 e2", pass, truth);
    end
    // Short settle: only vector 0 (already stable from IDLE) reads right.
    expected1 = golden;
    et1 = ~golden;
    et1[0] = golden[0];
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    de1 = -1;
    for (int n = 0; n < 40; n++) begin
      if (done1 === 1'b1 && de1 < 0) de1 = n;
      @(posedge clk); #1;
    end
    checks++; if (de1 != 24) begin errors++; $display("[TB] FAIL settle1_done_edge: got %0d want 24", de1); end
    checks++; if (pass1 !== 1'b0) begin errors++; $display("[TB] FAIL settle1_pass: got %b want 0", pass1); end
    checks++; if (truth1 !== et1) begin errors++; $display("[TB] FAIL settle1_truth: got %h want %h", truth1, et1); end
  endtask

  task automatic test_back_to_back;
    int de, dp, se; bit bo;
    golden = 8'hE2;
    do_sweep(8'hE2, 1'b1, 1'b0, de, dp, se, bo);
    checks++; if (de != SWEEP || dp != 1) begin
      errors++; $display("[TB] FAIL b2b_done: got edge=%0d pulses=%0d want %0d 1", de, dp, SWEEP);
    end
    checks++; if (se != 0) begin errors++; $display("[TB] FAIL b2b_seq: got %0d bad cycles want 0", se); end
    checks++; if (truth !== 8'hE2 || pass !== 1'b1 || mismatch_cnt !== 4'd0) begin
      errors++; $display("[TB] FAIL b2b_result: got truth=%h pass=%b cnt=%0d want e2 1 0", truth, pass, mismatch_cnt);
    end
  endtask

  task automatic test_abort;
    bit found, saw_done, saw_busy;
    logic [7:0] et; logic [3:0] ec; logic [2:0] ei; logic ev;
    golden = 8'hE2;
    expected = 8'hE3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if ({D, X, A} == 3'd3) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    checks++; if (!found) begin errors++; $display("[TB] FAIL abort_reach: got no vector 3 want vector 3"); end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    model_sweep(golden, 8'hE3, 3, et, ec, ei, ev);
    checks++; if (busy !== 1'b0 || {D, X, A} !== 3'd0 || done !== 1'b0 || pass !== 1'b0) begin
      errors++; $display("[TB] FAIL abort_state: got busy=%b dxa=%b done=%b pass=%b want 0 000 0 0",
                         busy, {D, X, A}, done, pass);
    end
    checks++; if (truth !== et || truth[7:3] !== 5'd0) begin errors++; $display("[TB] FAIL abort_truth: got %h want %h", truth, et); end
    checks++; if (mismatch_cnt !== ec || first_fail_vld !== ev || first_fail_idx !== ei) begin
      errors++; $display("[TB] FAIL abort_score: got cnt=%0d vld=%b idx=%0d want %0d %b %0d",
                         mismatch_cnt, first_fail_vld, first_fail_idx, ec, ev, ei);
    end
    saw_done = 1'b0; saw_busy = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1'b1;
      if (busy === 1'b1) saw_busy = 1'b1;
    end
    checks++; if (saw_done || saw_busy) begin
      errors++; $display("[TB] FAIL abort_quiet: got done=%b busy=%b want 0 0", saw_done, saw_busy);
    end
  endtask

  task automatic test_async_reset;
    int de, dp, se; bit bo, found;
    golden = 8'hE2;
    expected = 8'hE2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if ({D, X, A} == 3'd4) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    checks++; if (!found) begin errors++; $display("[TB] FAIL arst_reach: got no vector 4 want vector 4"); end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, D, X, A, pass, first_fail_vld, first_fail_idx, mismatch_cnt, truth} !== '0) begin
      errors++;
      $display("[TB] FAIL arst_outputs: got busy=%b dxa=%b truth=%h cnt=%0d want all zero",
               busy, {D, X, A}, truth, mismatch_cnt);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL arst_idle: got busy=%b want 0", busy); end
    do_sweep(8'hE2, 1'b0, 1'b0, de, dp, se, bo);
    checks++; if (de != SWEEP || truth !== 8'hE2 || pass !== 1'b1) begin
      errors++; $display("[TB] FAIL arst_rerun: got edge=%0d truth=%h pass=%b want %0d e2 1", de, truth, pass, SWEEP);
    end
  endtask

  task automatic test_random;
    int de, dp, se; bit bo;
    logic [7:0] exp_tbl, et; logic [3:0] ec; logic [2:0] ei; logic ev;
    for (int it = 0; it < 5; it++) begin
      golden = 8'($urandom);
      exp_tbl = ($urandom_range(0, 2) == 0) ? golden : (golden ^ 8'($urandom));
      // The first run also holds abort with start in IDLE; start must win.
      do_sweep(exp_tbl, 1'b0, (it == 0), de, dp, se, bo);
      model_sweep(golden, exp_tbl, 8, et, ec, ei, ev);
      checks++; if (de != SWEEP || dp != 1 || se != 0) begin
        errors++; $display("[TB] FAIL rand_timing: got edge=%0d pulses=%0d seq=%0d want %0d 1 0", de, dp, se, SWEEP);
      end
      checks++; if (truth !== et) begin errors++; $display("[TB] FAIL rand_truth: got %h want %h", truth, et); end
      checks++; if (mismatch_cnt !== ec || pass !== (ec == 4'd0)) begin
        errors++; $display("[TB] FAIL rand_score: got cnt=%0d pass=%b want %0d %b", mismatch_cnt, pass, ec, (ec == 4'd0));
      end
      checks++; if (first_fail_idx !== ei || first_fail_vld !== ev) begin
        errors++; $display("[TB] FAIL rand_first: got idx=%0d vld=%b want %0d %b", first_fail_idx, first_fail_vld, ei, ev);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    prev_vec = '0; prev_vec1 = '0; stable = 0; stable1 = 0;
    l_slow = 1'b0; l_slow1 = 1'b0;
    $display("[TB] starting comb_seq_ctrl bench");
    test_reset();
    test_match();
    test_mismatch();
    test_settle();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
